// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the main-memory controller.
package mem_ctrl_pkg;

   localparam int MEM_ADDR_W = 12;
   localparam int MEM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RD_BURST = 2'd2,
      WR_WAIT  = 2'd3
   } mem_state_t;

   typedef logic mem_rw_t;
   localparam mem_rw_t MEM_RD = 1'b0;
   localparam mem_rw_t MEM_WR = 1'b1;

   // Address of the beat 'step' positions after 'base_addr' within its line.
   // Bits outside off_mask are held; bits inside wrap modulo the line size.
   function automatic logic [MEM_ADDR_W-1:0] wrap_addr(
      input logic [MEM_ADDR_W-1:0] base_addr,
      input logic [MEM_ADDR_W-1:0] step,
      input logic [MEM_ADDR_W-1:0] off_mask
   );
      wrap_addr = (base_addr & ~off_mask) | ((base_addr + step) & off_mask);
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bus between the cache and the memory controller.
interface mem_ctrl_if;
   import mem_ctrl_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   mem_rw_t               req_rw;
   logic [MEM_ADDR_W-1:0] req_addr;
   logic [MEM_DATA_W-1:0] req_wdata;
   logic                  rsp_valid;
   logic [MEM_DATA_W-1:0] rsp_data;
   logic [MEM_ADDR_W-1:0] rsp_addr;
   logic                  rsp_last;
   logic                  wr_done;
   logic                  busy;

   modport master (
      output req_valid, req_rw, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, wr_done, busy
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, wr_done, busy
   );

endinterface

// File: rtl/mem_ctrl_mem_array.sv
// Single-port synchronous byte RAM, registered read, contents not reset.
module mem_array #(
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Write port and one-cycle read port share the address.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory controller: one request at a time, critical-word-first
// read bursts after READ_LAT edges, single-byte writes after WRITE_LAT edges.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request; latches addr/wdata on acceptance
// RD_WAIT  | counting read latency; last edge issues the beat-0 RAM read
// RD_BURST | one beat per cycle, LINE_WORDS beats, offset wraps in line
// WR_WAIT  | counting write latency; last edge commits the byte
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int READ_LAT   = 3,
   parameter int WRITE_LAT  = 2,
   parameter int DEPTH      = 4096
) (
   input  logic       clk,
   input  logic       rst,
   mem_ctrl_if.slave  bus
);

   localparam int BEAT_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

   localparam logic [LAT_W-1:0]      RD_LOAD   = LAT_W'(READ_LAT - 1);
   localparam logic [LAT_W-1:0]      WR_LOAD   = LAT_W'(WRITE_LAT - 1);
   localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(LINE_WORDS - 1);
   localparam logic [MEM_ADDR_W-1:0] OFF_MASK  = MEM_ADDR_W'(LINE_WORDS - 1);

   mem_state_t            state_q,   state_d;
   logic [LAT_W-1:0]      lat_q,     lat_d;
   logic [BEAT_W-1:0]     beat_q,    beat_d;
   logic [MEM_ADDR_W-1:0] addr_q,    addr_d;
   logic [MEM_DATA_W-1:0] wdata_q,   wdata_d;
   logic                  wr_done_q, wr_done_d;

   logic                  ram_we;
   logic [MEM_ADDR_W-1:0] ram_addr;
   logic [MEM_DATA_W-1:0] ram_rdata;
   logic                  in_burst;

   // State, counters and latched request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         lat_q     <= '0;
         beat_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_q     <= lat_d;
         beat_q    <= beat_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_done_q <= wr_done_d;
      end
   end

   // Next-state logic, latency down-counter and beat counter.
   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      beat_d    = beat_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_done_d = 1'b0;
      ram_we    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               beat_d  = '0;
               if (bus.req_rw == MEM_RD) begin
                  state_d = RD_WAIT;
                  lat_d   = RD_LOAD;
               end else begin
                  state_d = WR_WAIT;
                  lat_d   = WR_LOAD;
               end
            end
         end
         RD_WAIT: begin
            if (lat_q == '0) begin
               state_d = RD_BURST;
               beat_d  = '0;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         RD_BURST: begin
            if (beat_q == BEAT_LAST) begin
               state_d = IDLE;
               beat_d  = '0;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         WR_WAIT: begin
            if (lat_q == '0) begin
               ram_we    = 1'b1;
               wr_done_d = 1'b1;
               state_d   = IDLE;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM reads one beat ahead: the latched address during RD_WAIT, the
   // following beat's address while a burst is on the bus.
   assign in_burst = (state_q == RD_BURST);
   assign ram_addr = in_burst
                   ? wrap_addr(addr_q, MEM_ADDR_W'(beat_q) + MEM_ADDR_W'(1), OFF_MASK)
                   : addr_q;

   mem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (MEM_ADDR_W),
      .DATA_W (MEM_DATA_W)
   ) u_mem_array (
      .clk     (clk),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   // Outputs decode from registered state so reset clears them at once.
   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.rsp_valid = in_burst;
   assign bus.rsp_last  = in_burst && (beat_q == BEAT_LAST);
   assign bus.rsp_addr  = in_burst ? wrap_addr(addr_q, MEM_ADDR_W'(beat_q), OFF_MASK) : '0;
   assign bus.rsp_data  = in_burst ? ram_rdata : '0;
   assign bus.wr_done   = wr_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   localparam int LW = 4;
   localparam int RL = 3;
   localparam int WL = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   mem_ctrl_if bus();

   mem_ctrl #(.LINE_WORDS(LW), .READ_LAT(RL), .WRITE_LAT(WL), .DEPTH(4096)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         cyc         = 0;
   int         ready_from  = 0;
   int         rd_first    = 0;
   int         wr_commit   = 0;
   int         wr_done_cyc = -1;
   bit         rd_act      = 0;
   bit         wr_pend     = 0;
   int         rd_addr     = 0;
   int         wa          = 0;
   logic [7:0] wd          = 0;
   logic [7:0] mmem  [4096];
   bit         known [4096];

   function automatic int beat_addr(input int a, input int k);
      int base;
      base = a - (a % LW);
      return base + ((a % LW) + k) % LW;
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst) begin
         rd_act = 0; wr_pend = 0; ready_from = cyc; wr_done_cyc = -1;
      end else begin
         if (wr_pend && cyc == wr_commit) begin
            mmem[wa] = wd; known[wa] = 1; wr_pend = 0; wr_done_cyc = cyc;
         end
         if (bus.req_valid === 1'b1 && (cyc - 1) >= ready_from) begin
            if (bus.req_rw == MEM_WR) begin
               wr_pend = 1; wa = int'(bus.req_addr); wd = bus.req_wdata;
               wr_commit = cyc + WL; ready_from = cyc + WL;
            end else begin
               rd_act = 1; rd_addr = int'(bus.req_addr);
               rd_first = cyc + RL; ready_from = cyc + RL + LW;
            end
         end
      end
   end

   always @(negedge rst) begin
      rd_act = 0; wr_pend = 0; ready_from = cyc; wr_done_cyc = -1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : cmp
      int  k, a;
      bit  act, exp_ready;
      if (!rst) begin
         chk("rst_ready", bus.req_ready, 1);
         chk("rst_busy",  bus.busy, 0);
         chk("rst_valid", bus.rsp_valid, 0);
         chk("rst_wrdone", bus.wr_done, 0);
         chk("rst_last",  bus.rsp_last, 0);
      end else begin
         exp_ready = (cyc >= ready_from);
         chk("ready", bus.req_ready, exp_ready);
         chk("busy",  bus.busy, !exp_ready);
         k   = cyc - rd_first;
         act = rd_act && k >= 0 && k < LW;
         chk("rsp_valid", bus.rsp_valid, act);
         chk("rsp_last",  bus.rsp_last, act && k == LW - 1);
         if (act) begin
            a = beat_addr(rd_addr, k);
            chk("rsp_addr", bus.rsp_addr, a);
            if (known[a]) chk("rsp_data", bus.rsp_data, mmem[a]);
         end
         chk("wr_done", bus.wr_done, cyc == wr_done_cyc);
      end
   end

   // ---------------- observation monitor ----------------
   logic [11:0] mq_addr [$];
   logic [7:0]  mq_data [$];
   bit          mq_last [$];
   int          first_valid_cyc = 0;
   int          wr_cnt = 0;
   int          wr_seen_cyc = -1;

   always @(negedge clk) begin
      if (bus.rsp_valid === 1'b1) begin
         if (mq_addr.size() == 0) first_valid_cyc = cyc;
         mq_addr.push_back(bus.rsp_addr);
         mq_data.push_back(bus.rsp_data);
         mq_last.push_back(bus.rsp_last);
      end
      if (bus.wr_done === 1'b1) begin
         wr_cnt++;
         wr_seen_cyc = cyc;
      end
   end

   // ---------------- helpers ----------------
   task automatic clear_q();
      mq_addr.delete(); mq_data.delete(); mq_last.delete();
   endtask

   // Caller is away from the clock edge; holds the request until accepted.
   task automatic issue(input bit rw, input logic [11:0] a, input logic [7:0] d, output int acc);
      int b = 0;
      bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_addr = a; bus.req_wdata = d;
      while (bus.req_ready !== 1'b1 && b < 100) begin
         @(negedge clk); #1; b++;
      end
      if (b >= 100) chk("accept_timeout", b, 0);
      @(posedge clk); #1;
      acc = cyc;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_wr(input int n_before);
      int b = 0;
      while (wr_cnt <= n_before && b < 50) begin @(negedge clk); #1; b++; end
      if (b >= 50) chk("wr_timeout", b, 0);
   endtask

   task automatic wait_rd();
      int b = 0;
      while (mq_addr.size() < LW && b < 50) begin @(negedge clk); #1; b++; end
      if (b >= 50) chk("rd_timeout", b, 0);
   endtask

   task automatic do_write(input logic [11:0] a, input logic [7:0] d);
      int n, acc;
      n = wr_cnt;
      issue(1'b1, a, d, acc);
      wait_wr(n);
      chk("wr_latency", wr_seen_cyc - acc, 2);
   endtask

   task automatic do_read(input logic [11:0] a);
      int acc;
      clear_q();
      issue(1'b0, a, 8'h00, acc);
      wait_rd();
      chk("rd_latency", first_valid_cyc - acc, 3);
   endtask

   task automatic chk_burst(input string nm, input logic [11:0] ea [4], input logic [7:0] ed [4]);
      for (int i = 0; i < 4; i++) begin
         chk({nm, "_addr"}, (mq_addr.size() > i) ? mq_addr[i] : 12'hxxx, ea[i]);
         chk({nm, "_data"}, (mq_data.size() > i) ? mq_data[i] : 8'hxx, ed[i]);
         chk({nm, "_last"}, (mq_last.size() > i) ? mq_last[i] : 1'b0, i == 3);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [11:0] ea [4];
      logic [7:0]  ed [4];
      logic [11:0] pool [5];
      int acc, acc_r, acc_w, n, b;

      bus.req_valid = 1'b0; bus.req_rw = MEM_RD; bus.req_addr = '0; bus.req_wdata = '0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1 rst = 1'b1;
      @(negedge clk); #1;
      chk("idle_ready", bus.req_ready, 1);
      chk("idle_busy",  bus.busy, 0);
      chk("idle_valid", bus.rsp_valid, 0);
      chk("idle_wrdone", bus.wr_done, 0);

      // write then read a line
      do_write(12'h100, 8'h11);
      do_write(12'h101, 8'h22);
      do_write(12'h102, 8'h33);
      do_write(12'h103, 8'h44);
      do_read(12'h100);
      ea = '{12'h100, 12'h101, 12'h102, 12'h103};
      ed = '{8'h11, 8'h22, 8'h33, 8'h44};
      chk_burst("line", ea, ed);
      @(negedge clk); #1;
      chk("ready_after_last", bus.req_ready, 1);

      // critical word first
      do_read(12'h102);
      ea = '{12'h102, 12'h103, 12'h100, 12'h101};
      ed = '{8'h33, 8'h44, 8'h11, 8'h22};
      chk_burst("wrap", ea, ed);

      // write held while a burst is in progress
      clear_q();
      n = wr_cnt;
      issue(1'b0, 12'h100, 8'h00, acc_r);
      issue(1'b1, 12'h200, 8'hAA, acc_w);
      chk("busy_hold_accept", acc_w - acc_r, 8);
      wait_wr(n);
      do_read(12'h200);
      chk("raw_data", mq_data[0], 8'hAA);
      chk("raw_addr", mq_addr[0], 12'h200);

      // top of the address space
      do_write(12'hFFC, 8'hC0);
      do_write(12'hFFD, 8'hC1);
      do_write(12'hFFE, 8'hC2);
      do_write(12'hFFF, 8'hC3);
      do_read(12'hFFE);
      ea = '{12'hFFE, 12'hFFF, 12'hFFC, 12'hFFD};
      ed = '{8'hC2, 8'hC3, 8'hC0, 8'hC1};
      chk_burst("top", ea, ed);

      // reset during beat 1 of a burst
      clear_q();
      issue(1'b0, 12'h100, 8'h00, acc);
      b = 0;
      while (cyc < acc + 3 && b < 20) begin @(negedge clk); b++; end
      @(posedge clk); #2;
      chk("abort_pre_valid", bus.rsp_valid, 1);
      rst = 1'b0;
      #1;
      chk("abort_valid", bus.rsp_valid, 0);
      chk("abort_last",  bus.rsp_last, 0);
      chk("abort_ready", bus.req_ready, 1);
      chk("abort_busy",  bus.busy, 0);
      chk("abort_addr",  bus.rsp_addr, 0);
      chk("abort_data",  bus.rsp_data, 0);
      @(negedge clk); #1 rst = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      chk("abort_beats", mq_addr.size(), 1);

      // reset before a write commits
      do_write(12'h300, 8'h00);
      n = wr_cnt;
      issue(1'b1, 12'h300, 8'h55, acc);
      #1 rst = 1'b0;
      #1;
      chk("wabort_busy", bus.busy, 0);
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("wabort_no_done", wr_cnt, n);
      do_read(12'h300);
      chk("wabort_data", mq_data[0], 8'h00);

      // randomized traffic
      pool = '{12'h100, 12'h200, 12'h300, 12'hFF8, 12'h5A0};
      for (int t = 0; t < 300; t++) begin
         logic [11:0] a;
         bit          rw;
         rw = 1'($urandom_range(0, 1));
         a  = pool[$urandom_range(0, 4)] + 12'($urandom_range(0, 7));
         issue(rw, a, 8'($urandom_range(0, 255)), acc);
         if ($urandom_range(0, 19) == 0) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            #2 rst = 1'b0;
            @(negedge clk); #1 rst = 1'b1;
         end else begin
            repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
         end
      end

      b = 0;
      while (bus.req_ready !== 1'b1 && b < 50) begin @(negedge clk); #1; b++; end
      if (b >= 50) chk("drain_timeout", b, 0);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
